nibble_word_serializer: RTL and testbench
=========================================

Name: nibble_word_serializer

Overview:
- Parallel-to-serial front end for the nibble-serial datapath.
- Accepts a 32-bit word on a valid/ready load port and emits it one 4-bit nibble per accepted beat on a valid/ready stream.
- Order is LSB-first (carry chains) or MSB-first (right shifts); the transfer is bounded by a programmable nibble count.
- Feeds the nibble loop and the nibble-wide memory bus from full-width registers.

Parameters:
- NIBBLES, 8, nibbles per word; word width is 4*NIBBLES.
- CNT_SIZE, 3, index/counter width; must equal $clog2(NIBBLES).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- load_valid  in  1  load request.
- load_ready  out  1  serializer can accept a word this cycle.
- load_word  in  4*NIBBLES  word to send.
- load_reverse  in  1  1 = MSB-first, 0 = LSB-first.
- load_len  in  CNT_SIZE  nibbles to send minus 1 (0 sends one nibble, 7 sends all eight).
- out_valid  out  1  out_nibble is valid.
- out_ready  in  1  sink accepts the beat.
- out_nibble  out  4  current nibble.
- out_idx  out  CNT_SIZE  word position of out_nibble.
- out_last  out  1  current beat is the final one of the word.
- busy  out  1  transfer in progress (state SEND).

Behaviour:
- Reset (async, rst=1): state IDLE.
  - out_valid=0, out_last=0, out_idx=0, out_nibble=0, busy=0.
  - Internal word register and counters cleared.
  - load_ready=1 after reset release.
- States:
  - IDLE: load_ready=1, out_valid=0.
  - SEND: out_valid=1.
- Load accept: load_valid && load_ready at a rising edge.
  - Captures load_word, load_reverse and load_len.
  - Enters SEND next cycle; the first beat is visible the cycle after accept (1-cycle latency).
- Start index:
  - Forward: 0.
  - Reverse: NIBBLES-1.
- Beat accept: out_valid && out_ready.
  - Index steps +1 (forward) or -1 (reverse); remaining count decrements.
  - out_nibble and out_idx hold stable while out_valid && !out_ready (no change until accepted).
- out_last=1 when the remaining count is 0.
  - Forward: last index = load_len.
  - Reverse: last index = NIBBLES-1-load_len.
- Last beat accepted, no new load: return to IDLE; out_valid drops the next cycle.
- Back-to-back: load_ready is also 1 in SEND when out_last && out_ready.
  - A load accepted in that cycle starts the next word with no bubble (first beat of the new word in the next cycle).
- Index arithmetic never wraps: load_len is bounded by NIBBLES-1, so a reverse transfer ends at index 0 or above.
- load_valid while busy and not on the last accepted beat: ignored (load_ready=0); the word is not captured.
- rst mid-transfer: immediate abort to IDLE; remaining nibbles are discarded and out_valid=0 asynchronously.
- out_ready while IDLE: ignored.

Optional Feature:
- Macro: NIBBLE_SER_TRIM_ZERO_EN.
- Defined: at load, the effective length is shortened so that trailing all-zero nibbles in the send direction are not emitted.
  - Forward trims high zero nibbles; reverse trims low zero nibbles.
  - At least one nibble is always sent (load_word=0 sends one zero nibble with out_last=1).
  - load_len still caps the length.
  - The trim is computed combinationally at load; latency is unchanged.
- Undefined: exactly load_len+1 nibbles are always sent.

Test Plan:
- Forward, load_word=32'h8765_4321, load_len=7, out_ready=1 -> nibbles 1,2,...,8 on consecutive cycles; out_idx 0..7; out_last only at idx 7; load_ready=1 again after the last beat.
- Reverse, load_word=32'h0600_0000, load_len=7 -> nibbles 0,6,0,0,0,0,0,0; out_idx 7 down to 0; out_last at idx 0.
- Forward, load_len=2, word 32'hABCD_EF12, out_ready toggling 1,0,0,1,1 -> nibbles 2,1,F emitted, each held stable during stalls; out_last with F (idx 2).
- Back-to-back: second load (32'h0000_00FF, len 1) asserted during the last beat of the first word -> 4'hF,4'hF follow with no idle cycle.
- rst asserted after the 3rd beat of a full forward transfer -> out_valid=0 and busy=0 immediately; after release, load_ready=1 and a new word sends from idx 0.
- With NIBBLE_SER_TRIM_ZERO_EN: forward 32'h0000_0F01, len 7 -> 3 beats (1,0,F), out_last at idx 2; load_word=0 -> a single beat 0 with out_last. Without the macro -> 8 beats for both.

Source files
------------

// File: rtl/nibble_word_serializer.sv
// Parallel-to-serial front end: loads a word on a valid/ready port and streams it as nibbles,
// LSB-first or MSB-first. Optional zero-trim of the tail is enabled by NIBBLE_SER_TRIM_ZERO_EN.
module nibble_word_serializer #(
    parameter int NIBBLES  = 8,
    parameter int CNT_SIZE = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [4*NIBBLES-1:0]   load_word,
    input  logic                   load_reverse,
    input  logic [CNT_SIZE-1:0]    load_len,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3:0]             out_nibble,
    output logic [CNT_SIZE-1:0]    out_idx,
    output logic                   out_last,
    output logic                   busy
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                 state_q, state_d;
    logic [4*NIBBLES-1:0]   word_q, word_d;
    logic                   rev_q, rev_d;
    logic [CNT_SIZE-1:0]    idx_q, idx_d;
    logic [CNT_SIZE-1:0]    rem_q, rem_d;
    logic [3:0]             nibble_q, nibble_d;
    logic                   last_q, last_d;

    logic [CNT_SIZE-1:0]    len_eff;
    logic [CNT_SIZE-1:0]    start_idx;
    logic [CNT_SIZE-1:0]    idx_next;
    logic                   load_acc;
    logic                   beat_acc;

`ifdef NIBBLE_SER_TRIM_ZERO_EN
    logic [CNT_SIZE-1:0]    fwd_len;
    logic [CNT_SIZE-1:0]    rev_len;
    logic [CNT_SIZE-1:0]    trim_len;

    // Length needed to reach the farthest non-zero nibble in the send direction.
    always_comb begin
        fwd_len = '0;
        rev_len = '0;
        for (int unsigned i = 0; i < NIBBLES; i++) begin
            if (load_word[4*i +: 4] != '0)
                fwd_len = CNT_SIZE'(i);
            if (load_word[4*(NIBBLES-1-i) +: 4] != '0)
                rev_len = CNT_SIZE'(i);
        end
        trim_len = load_reverse ? rev_len : fwd_len;
        len_eff  = (trim_len < load_len) ? trim_len : load_len;
    end
`else
    assign len_eff = load_len;
`endif

    assign out_valid  = (state_q == SEND);
    assign busy       = (state_q == SEND);
    assign out_nibble = nibble_q;
    assign out_idx    = idx_q;
    assign out_last   = last_q;
    // A new word may be taken while the final beat of the current one is accepted.
    assign load_ready = (state_q == IDLE) || (last_q && out_ready);

    assign load_acc  = load_valid && load_ready;
    assign beat_acc  = (state_q == SEND) && out_ready;
    assign start_idx = load_reverse ? CNT_SIZE'(NIBBLES - 1) : '0;
    assign idx_next  = rev_q ? (idx_q - CNT_SIZE'(1)) : (idx_q + CNT_SIZE'(1));

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        rev_d    = rev_q;
        idx_d    = idx_q;
        rem_d    = rem_q;
        nibble_d = nibble_q;
        last_d   = last_q;
        if (load_acc) begin
            state_d  = SEND;
            word_d   = load_word;
            rev_d    = load_reverse;
            idx_d    = start_idx;
            rem_d    = len_eff;
            nibble_d = load_word[4*int'(start_idx) +: 4];
            last_d   = (len_eff == '0);
        end else if (beat_acc) begin
            if (rem_q == '0) begin
                state_d = IDLE;
                last_d  = 1'b0;
            end else begin
                idx_d    = idx_next;
                rem_d    = rem_q - CNT_SIZE'(1);
                nibble_d = word_q[4*int'(idx_next) +: 4];
                last_d   = (rem_q == CNT_SIZE'(1));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            word_q   <= '0;
            rev_q    <= 1'b0;
            idx_q    <= '0;
            rem_q    <= '0;
            nibble_q <= '0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            rev_q    <= rev_d;
            idx_q    <= idx_d;
            rem_q    <= rem_d;
            nibble_q <= nibble_d;
            last_q   <= last_d;
        end
    end

endmodule

// File: tb/tb_nibble_word_serializer.sv
// Randomized and directed bench for nibble_word_serializer against a queue-based beat model.
module tb_nibble_word_serializer;

    logic        clk;
    logic        rst;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] load_word;
    logic        load_reverse;
    logic [2:0]  load_len;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_nibble;
    logic [2:0]  out_idx;
    logic        out_last;
    logic        busy;

    int total;
    int bad;

    typedef struct {
        logic [3:0] nib;
        logic [2:0] idx;
    } beat_t;

    beat_t exp_q[$];

    nibble_word_serializer #(.NIBBLES(8), .CNT_SIZE(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_word    (load_word),
        .load_reverse (load_reverse),
        .load_len     (load_len),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_nibble   (out_nibble),
        .out_idx      (out_idx),
        .out_last     (out_last),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Builds the expected beat list for one word from the transfer rules.
    task automatic push_word(input logic [31:0] w, input logic rv, input logic [2:0] ln);
        int          n;
        int          sig;
        logic [31:0] tmp;
        beat_t       b;
        n = int'(ln) + 1;
`ifdef NIBBLE_SER_TRIM_ZERO_EN
        tmp = w;
        sig = 0;
        if (!rv) begin
            while (tmp != 0) begin
                sig++;
                tmp = tmp >> 4;
            end
        end else if (tmp != 0) begin
            sig = 8;
            while ((tmp & 32'hF) == 0) begin
                sig--;
                tmp = tmp >> 4;
            end
        end
        if (sig < 1) sig = 1;
        if (sig < n) n = sig;
`else
        tmp = w;
        sig = n;
`endif
        for (int i = 0; i < n; i++) begin
            b.idx = rv ? 3'(7 - i) : 3'(i);
            tmp   = w >> (4 * int'(b.idx));
            b.nib = tmp[3:0];
            exp_q.push_back(b);
        end
    endtask

    // One clock cycle: check registered outputs, drive inputs, check load_ready, advance model.
    task automatic step(input logic lv, input logic [31:0] w, input logic rv,
                        input logic [2:0] ln, input logic ordy);
        logic exp_ready;
        @(negedge clk);
        if (exp_q.size() != 0) begin
            check("out_valid", 32'(out_valid), 32'd1);
            check("busy", 32'(busy), 32'd1);
            check("out_nibble", 32'(out_nibble), 32'(exp_q[0].nib));
            check("out_idx", 32'(out_idx), 32'(exp_q[0].idx));
            check("out_last", 32'(out_last), 32'(exp_q.size() == 1));
        end else begin
            check("out_valid_idle", 32'(out_valid), 32'd0);
            check("busy_idle", 32'(busy), 32'd0);
            check("out_last_idle", 32'(out_last), 32'd0);
        end
        load_valid   = lv;
        load_word    = w;
        load_reverse = rv;
        load_len     = ln;
        out_ready    = ordy;
        #1;
        exp_ready = (exp_q.size() == 0) || ((exp_q.size() == 1) && ordy);
        check("load_ready", 32'(load_ready), 32'(exp_ready));
        if ((exp_q.size() != 0) && ordy)
            void'(exp_q.pop_front());
        if (lv && exp_ready)
            push_word(w, rv, ln);
    endtask

    task automatic idle_cycles(input int n, input logic ordy);
        for (int i = 0; i < n; i++)
            step(1'b0, $urandom, 1'b0, 3'd0, ordy);
    endtask

    initial begin
        logic [31:0] w;
        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        load_valid   = 1'b0;
        load_word    = '0;
        load_reverse = 1'b0;
        load_len     = '0;
        out_ready    = 1'b0;
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_out_nibble", 32'(out_nibble), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Forward full word, then reverse with a single set nibble.
        step(1'b1, 32'h8765_4321, 1'b0, 3'd7, 1'b1);
        idle_cycles(9, 1'b1);
        step(1'b1, 32'h0600_0000, 1'b1, 3'd7, 1'b1);
        idle_cycles(9, 1'b1);

        // Short forward word with stalls.
        step(1'b1, 32'hABCD_EF12, 1'b0, 3'd2, 1'b1);
        step(1'b0, '0, 1'b0, 3'd0, 1'b1);
        step(1'b0, '0, 1'b0, 3'd0, 1'b0);
        step(1'b0, '0, 1'b0, 3'd0, 1'b0);
        step(1'b0, '0, 1'b0, 3'd0, 1'b1);
        step(1'b0, '0, 1'b0, 3'd0, 1'b1);
        idle_cycles(2, 1'b1);

        // Back-to-back: second load offered while the first word is on its last beat.
        step(1'b1, 32'h1234_5678, 1'b0, 3'd1, 1'b1);
        step(1'b0, '0, 1'b0, 3'd0, 1'b1);
        step(1'b1, 32'h0000_00FF, 1'b0, 3'd1, 1'b1);
        idle_cycles(4, 1'b1);

        // Reset in the middle of a full forward transfer.
        step(1'b1, 32'hFEDC_BA98, 1'b0, 3'd7, 1'b1);
        idle_cycles(3, 1'b1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        exp_q.delete();
        #1 rst = 1'b0;
        step(1'b1, 32'h0BAD_F00D, 1'b0, 3'd7, 1'b1);
        idle_cycles(9, 1'b1);

        // Trim cases (default build sends every requested nibble).
        step(1'b1, 32'h0000_0F01, 1'b0, 3'd7, 1'b1);
        idle_cycles(9, 1'b1);
        step(1'b1, 32'h0000_0000, 1'b0, 3'd7, 1'b1);
        idle_cycles(9, 1'b1);
        step(1'b1, 32'h0000_0000, 1'b1, 3'd7, 1'b1);
        idle_cycles(9, 1'b1);
        step(1'b1, 32'h0A00_0000, 1'b1, 3'd7, 1'b1);
        idle_cycles(9, 1'b1);

        // Random traffic with sparse words to exercise zero nibbles.
        for (int i = 0; i < 3000; i++) begin
            w = $urandom;
            if ($urandom_range(0, 2) == 0)
                w = w & ($urandom & $urandom);
            if ($urandom_range(0, 9) == 0)
                w = '0;
            step(($urandom_range(0, 9) < 4), w, 1'($urandom), 3'($urandom),
                 ($urandom_range(0, 9) < 7));
        end
        idle_cycles(12, 1'b1);
        check("drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
